// File: rtl/address_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : address_capture_if
// Description : Address stream input and published address outputs of the
//               address_capture block. The slave modport is the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface address_capture_if;
    logic [8:0]  address_set;   // {strobe, byte}
    logic [47:0] mac_addr;
    logic [31:0] ip_addr;
    logic        addr_valid;
    logic        commit;
    logic        error;
    logic        busy;

    modport master (
        output address_set,
        input  mac_addr, ip_addr, addr_valid, commit, error, busy
    );

    modport slave (
        input  address_set,
        output mac_addr, ip_addr, addr_valid, commit, error, busy
    );
endinterface
`default_nettype wire

// File: rtl/address_capture.sv
`default_nettype none
// ============================================================================
// Module      : address_capture
// Description : Assembles a 6-byte MAC + 4-byte IP burst from the strobed
//               byte stream into shadow registers, checks the IP network
//               prefix and publishes both addresses atomically on completion.
// Revision    : 1.0 - initial release
// ============================================================================
module address_capture #(
    parameter int          GAP_MAX   = 16,
    parameter logic [31:0] IP_NET    = 32'h80038000,
    parameter bit          CHECK_NET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,      // synchronous, active low
    address_capture_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_IP   = 2'd2
    } state_t;

    // Gap value whose next idle cycle ends the burst.
    localparam logic [7:0] c_gap_last = 8'(GAP_MAX - 1);

    state_t      r_state;
    logic [3:0]  r_count;
    logic [7:0]  r_gap;
    logic [47:0] r_mac_sh;
    logic [23:0] r_ip_sh;
    logic [47:0] r_mac_pub;
    logic [31:0] r_ip_pub;
    logic        r_valid;
    logic        r_commit;
    logic        r_error;

    logic        w_strobe;
    logic [7:0]  w_byte;
    logic [7:0]  w_net_byte;
    logic        w_net_bad;
    logic        w_timeout;
    logic        w_abort;
    logic        w_commit;

    assign w_strobe = bus.address_set[8];
    assign w_byte   = bus.address_set[7:0];

    // Expected network byte for the IP byte currently arriving (count 6..8).
    always_comb begin
        w_net_byte = IP_NET[31:24];
        case (r_count)
            4'd7:    w_net_byte = IP_NET[23:16];
            4'd8:    w_net_byte = IP_NET[15:8];
            default: w_net_byte = IP_NET[31:24];
        endcase
    end

    assign w_net_bad = CHECK_NET && (r_count <= 4'd8) && (w_byte != w_net_byte);
    assign w_timeout = (r_state != ST_IDLE) && !w_strobe && (r_gap == c_gap_last);
    assign w_abort   = w_timeout || ((r_state == ST_IP) && w_strobe && w_net_bad);
    assign w_commit  = (r_state == ST_IP) && w_strobe && !w_net_bad && (r_count == 4'd9);

    // Burst sequencer: shadow assembly, gap supervision, abort and commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_count   <= 4'd0;
            r_gap     <= 8'd0;
            r_mac_sh  <= 48'd0;
            r_ip_sh   <= 24'd0;
            r_mac_pub <= 48'd0;
            r_ip_pub  <= 32'd0;
            r_valid   <= 1'b0;
            r_commit  <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_commit <= w_commit;
            r_error  <= w_abort;
            if (w_abort || w_commit) begin
                if (w_commit) begin
                    r_mac_pub <= r_mac_sh;
                    r_ip_pub  <= {r_ip_sh, w_byte};
                    r_valid   <= 1'b1;
                end
                r_state  <= ST_IDLE;
                r_count  <= 4'd0;
                r_gap    <= 8'd0;
                r_mac_sh <= 48'd0;
                r_ip_sh  <= 24'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_strobe) begin
                            r_mac_sh <= {40'd0, w_byte};
                            r_ip_sh  <= 24'd0;
                            r_count  <= 4'd1;
                            r_gap    <= 8'd0;
                            r_state  <= ST_MAC;
                        end
                    end
                    ST_MAC: begin
                        if (w_strobe) begin
                            r_mac_sh <= {r_mac_sh[39:0], w_byte};
                            r_count  <= r_count + 4'd1;
                            r_gap    <= 8'd0;
                            if (r_count == 4'd5) begin
                                r_state <= ST_IP;
                            end
                        end else begin
                            r_gap <= r_gap + 8'd1;
                        end
                    end
                    ST_IP: begin
                        if (w_strobe) begin
                            r_ip_sh <= {r_ip_sh[15:0], w_byte};
                            r_count <= r_count + 4'd1;
                            r_gap   <= 8'd0;
                        end else begin
                            r_gap <= r_gap + 8'd1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.mac_addr   = r_mac_pub;
    assign bus.ip_addr    = r_ip_pub;
    assign bus.addr_valid = r_valid;
    assign bus.commit     = r_commit;
    assign bus.error      = r_error;
    assign bus.busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_address_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_address_capture
// Description : Self-checking bench for address_capture. Two instances (net
//               check on / off) share one stimulus stream; a queue-style
//               burst model predicts every output on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_address_capture;

    localparam int          GAP_MAX = 16;
    localparam logic [31:0] IP_NET  = 32'h80038000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [8:0] aset = 9'd0;
    logic       chk_en = 1'b0;
    int         total = 0;
    int         bad   = 0;

    address_capture_if bus0 ();
    address_capture_if bus1 ();
    assign bus0.address_set = aset;
    assign bus1.address_set = aset;

    address_capture #(.GAP_MAX(GAP_MAX), .IP_NET(IP_NET), .CHECK_NET(1'b1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    address_capture #(.GAP_MAX(GAP_MAX), .IP_NET(IP_NET), .CHECK_NET(1'b0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #4 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: a burst is a list of received bytes plus an idle
    // run length; index 0 models net check on, index 1 net check off.
    // ------------------------------------------------------------------
    logic [7:0]  mbuf [2][10];
    int          mcnt [2];
    int          midle [2];
    logic [47:0] exp_mac [2];
    logic [31:0] exp_ip [2];
    logic        exp_valid [2];
    logic        exp_commit [2];
    logic        exp_error [2];
    logic        exp_busy [2];

    function automatic logic [7:0] net_byte(input int k);
        logic [31:0] v;
        v = IP_NET >> (24 - 8 * k);
        return v[7:0];
    endfunction

    task automatic model_step(input int m, input bit chk_net);
        logic       st;
        logic [7:0] b;
        st = aset[8];
        b  = aset[7:0];
        exp_commit[m] = 1'b0;
        exp_error[m]  = 1'b0;
        if (!rst) begin
            mcnt[m] = 0; midle[m] = 0;
            exp_mac[m] = '0; exp_ip[m] = '0; exp_valid[m] = 1'b0;
        end else if (mcnt[m] == 0) begin
            if (st) begin
                mbuf[m][0] = b; mcnt[m] = 1; midle[m] = 0;
            end
        end else if (!st) begin
            midle[m] = midle[m] + 1;
            if (midle[m] == GAP_MAX) begin
                mcnt[m] = 0; exp_error[m] = 1'b1;
            end
        end else if (chk_net && mcnt[m] >= 6 && mcnt[m] <= 8 && b != net_byte(mcnt[m] - 6)) begin
            mcnt[m] = 0; exp_error[m] = 1'b1;
        end else begin
            mbuf[m][mcnt[m]] = b;
            mcnt[m] = mcnt[m] + 1;
            midle[m] = 0;
            if (mcnt[m] == 10) begin
                exp_mac[m] = {mbuf[m][0], mbuf[m][1], mbuf[m][2], mbuf[m][3], mbuf[m][4], mbuf[m][5]};
                exp_ip[m]  = {mbuf[m][6], mbuf[m][7], mbuf[m][8], mbuf[m][9]};
                exp_valid[m]  = 1'b1;
                exp_commit[m] = 1'b1;
                mcnt[m] = 0;
            end
        end
        exp_busy[m] = (mcnt[m] != 0);
    endtask

    // Model advances on the same edge that the DUTs sample their inputs.
    always @(posedge clk) begin
        model_step(0, 1'b1);
        model_step(1, 1'b0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("mac0",    64'(bus0.mac_addr),   64'(exp_mac[0]));
            check("ip0",     64'(bus0.ip_addr),    64'(exp_ip[0]));
            check("valid0",  64'(bus0.addr_valid), 64'(exp_valid[0]));
            check("commit0", 64'(bus0.commit),     64'(exp_commit[0]));
            check("error0",  64'(bus0.error),      64'(exp_error[0]));
            check("busy0",   64'(bus0.busy),       64'(exp_busy[0]));
            check("mac1",    64'(bus1.mac_addr),   64'(exp_mac[1]));
            check("ip1",     64'(bus1.ip_addr),    64'(exp_ip[1]));
            check("valid1",  64'(bus1.addr_valid), 64'(exp_valid[1]));
            check("commit1", 64'(bus1.commit),     64'(exp_commit[1]));
            check("error1",  64'(bus1.error),      64'(exp_error[1]));
            check("busy1",   64'(bus1.busy),       64'(exp_busy[1]));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers; every task leaves time at 1 ns after a rising edge.
    // ------------------------------------------------------------------
    task automatic strobe(input logic [7:0] b);
        aset = {1'b1, b};
        @(posedge clk);
        #1;
        aset = 9'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends bytes first..last of a 10-byte burst with gap idle cycles between.
    task automatic send(input logic [79:0] bytes, input int gap, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            strobe(bytes[79 - 8 * i -: 8]);
            if (i < last) idle(gap);
        end
    endtask

    localparam logic [79:0] C_BURST_A   = 80'h12555500012a_800380ac;
    localparam logic [79:0] C_BURST_B   = 80'h12555500012b_800380ad;
    localparam logic [79:0] C_BURST_BAD = 80'h12555500012a_800480ac;

    initial begin
        // Reset state.
        rst = 1'b0;
        idle(3);
        check("rst_mac",   64'(bus0.mac_addr),   64'h0);
        check("rst_ip",    64'(bus0.ip_addr),    64'h0);
        check("rst_valid", 64'(bus0.addr_valid), 64'h0);
        check("rst_busy",  64'(bus0.busy),       64'h0);
        chk_en = 1'b1;
        rst = 1'b1;
        idle(2);

        // Back-to-back strobes: commit visible one cycle after the 10th.
        send(C_BURST_A, 0, 0, 9);
        check("a_commit",    64'(bus0.commit),     64'h1);
        check("a_mac",       64'(bus0.mac_addr),   64'h12555500012a);
        check("a_ip",        64'(bus0.ip_addr),    64'h800380ac);
        check("a_valid",     64'(bus0.addr_valid), 64'h1);
        check("model_a_mac", 64'(exp_mac[0]),      64'h12555500012a);
        check("model_a_ip",  64'(exp_ip[0]),       64'h800380ac);
        idle(3);

        // Gaps of 3 and of GAP_MAX-1 still commit.
        send(C_BURST_A, 3, 0, 9);
        check("gap3_commit", 64'(bus0.commit), 64'h1);
        idle(2);
        send(C_BURST_A, GAP_MAX - 1, 0, 9);
        check("gapmax1_commit", 64'(bus0.commit), 64'h1);
        check("gapmax1_ip",     64'(bus0.ip_addr), 64'h800380ac);
        idle(2);

        // Gap of GAP_MAX after byte 4 times out; published values hold.
        send(C_BURST_A, 0, 0, 3);
        idle(GAP_MAX);
        check("timeout_error", 64'(bus0.error),    64'h1);
        check("timeout_mac",   64'(bus0.mac_addr), 64'h12555500012a);
        check("timeout_busy",  64'(bus0.busy),     64'h0);
        send(C_BURST_A, 0, 4, 9);
        idle(GAP_MAX + 4);

        // Network mismatch on IP byte 1: abort with check, commit without.
        send(C_BURST_BAD, 0, 0, 7);
        check("net_error0",  64'(bus0.error),  64'h1);
        check("net_commit0", 64'(bus0.commit), 64'h0);
        send(C_BURST_BAD, 0, 8, 9);
        check("nochk_commit1", 64'(bus1.commit),  64'h1);
        check("nochk_ip1",     64'(bus1.ip_addr), 64'h800480ac);
        check("chk_ip0_held",  64'(bus0.ip_addr), 64'h800380ac);
        idle(GAP_MAX + 4);

        // Commit A, then B with no dead cycle; A holds until B commits.
        send(C_BURST_A, 0, 0, 9);
        send(C_BURST_B, 0, 0, 8);
        check("ab_hold_mac", 64'(bus0.mac_addr), 64'h12555500012a);
        send(C_BURST_B, 0, 9, 9);
        check("ab_new_mac",  64'(bus0.mac_addr), 64'h12555500012b);
        check("ab_new_ip",   64'(bus0.ip_addr),  64'h800380ad);
        idle(2);

        // Reset mid-burst, then a clean burst.
        send(C_BURST_A, 0, 0, 6);
        rst = 1'b0;
        idle(2);
        check("mid_rst_mac",   64'(bus0.mac_addr),   64'h0);
        check("mid_rst_valid", 64'(bus0.addr_valid), 64'h0);
        check("mid_rst_busy",  64'(bus0.busy),       64'h0);
        rst = 1'b1;
        idle(1);
        send(C_BURST_B, 0, 0, 9);
        check("post_rst_commit", 64'(bus0.commit),   64'h1);
        check("post_rst_mac",    64'(bus0.mac_addr), 64'h12555500012b);
        check("post_rst_ip",     64'(bus0.ip_addr),  64'h800380ad);
        idle(GAP_MAX + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
